// File: rtl/uart_rx_deserializer_if.sv
// Byte-stream port of the UART receiver: serial line in, valid/ready bytes and error pulses out.
interface uart_rx_deserializer_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      input  rx, rx_ready,
      output rx_data, rx_valid, frame_err, overrun, busy
   );

   modport slave (
      output rx, rx_ready,
      input  rx_data, rx_valid, frame_err, overrun, busy
   );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver, mid-bit single sample; UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO over a one-byte holding register.
// Latency: byte valid the cycle after the stop-bit sample; rx edge seen 2 cycles late through the synchronizer.
// Backpressure: rx_valid/rx_ready; a byte completing into full storage is dropped with a one-cycle overrun pulse.
module uart_rx_deserializer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   uart_rx_deserializer_if.master bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int TW           = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_rx_deserializer: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_deserializer: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          rx_meta, rx_s, rx_s_q;
   logic          busy_q, frame_err_q, overrun_q;
   logic          tick0, fall, push, pop, full;
   logic          valid_int;
   logic [7:0]    data_int;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
         rx_s_q  <= rx_s;
      end
   end

   assign tick0 = (timer == '0);
   assign fall  = rx_s_q & ~rx_s;
   assign push  = (state == STOP) && tick0 && rx_s;
   assign pop   = valid_int && bus.rx_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (state != IDLE && !tick0) timer <= timer - TW'(1);
         case (state)
            IDLE: begin
               if (fall) begin
                  timer  <= HALF_RELOAD;
                  state  <= START;
                  busy_q <= 1'b1;
               end
            end
            START: begin
               if (tick0) begin
                  if (!rx_s) begin
                     timer   <= BIT_RELOAD;
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     // Line was back high at mid start bit: treat as a glitch.
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick0) begin
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  timer     <= BIT_RELOAD;
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (tick0) begin
                  state       <= rx_s ? IDLE : BREAK;
                  busy_q      <= ~rx_s;
                  frame_err_q <= ~rx_s;
               end
            end
            BREAK: begin
               // Hold off new frames until the line returns high.
               if (rx_s) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;

   assign full  = (count == (AW + 1)'(FIFO_DEPTH));
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && full && !pop;
         if (wr_en) begin
            mem[wr_ptr] <= shift_reg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign valid_int = (count != '0);
   assign data_int  = mem[rd_ptr];
`else
   logic [7:0] hold_dat;
   logic       hold_vld;

   assign full = hold_vld;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_dat  <= '0;
         hold_vld  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && full && !pop;
         if (push && (!full || pop)) begin
            hold_dat <= shift_reg;
            hold_vld <= 1'b1;
         end else if (pop) begin
            hold_vld <= 1'b0;
         end
      end
   end

   assign valid_int = hold_vld;
   assign data_int  = hold_dat;
`endif

   assign bus.rx_valid  = valid_int;
   assign bus.rx_data   = data_int;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at a 16-clock bit period; expected bytes flow through a scoreboard queue.
module tb_uart_rx_deserializer;
   localparam int CLK_FREQ_HZ = 1_000_000;
   localparam int BAUD_RATE   = 62_500;
   localparam int BIT_CLKS    = CLK_FREQ_HZ / BAUD_RATE;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   uart_rx_deserializer_if bus ();

   uart_rx_deserializer #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD_RATE   (BAUD_RATE),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;
   int         valid_cycles = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt  = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stop_low_bits);
      bus.rx = 1'b0;
      repeat (BIT_CLKS) tick();
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (BIT_CLKS) tick();
      end
      if (stop_low_bits > 0) begin
         bus.rx = 1'b0;
         repeat (stop_low_bits * BIT_CLKS) tick();
      end
      bus.rx = 1'b1;
      repeat (2 * BIT_CLKS) tick();
   endtask

   // Monitor: counts pulses and valid cycles, pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.rx_valid)  valid_cycles++;
         if (bus.frame_err) ferr_cnt++;
         if (bus.overrun)   ovr_cnt++;
         if (bus.frame_err || bus.overrun)
            check("err_exclusive", 32'(bus.frame_err & bus.overrun), 32'd0);
         if (bus.rx_valid && bus.rx_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
               n_fail++;
               $error("FAIL unexpected_byte: observed %0h expected none", bus.rx_data);
            end
            if (exp_q.size() != 0) check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int v0, f0, o0;
      bus.rx       = 1'b1;
      bus.rx_ready = 1'b0;
      resetn       = 1'b0;
      repeat (3) tick();
      check("rst_rx_data",   32'(bus.rx_data),   32'h00);
      check("rst_rx_valid",  32'(bus.rx_valid),  32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
      check("rst_overrun",   32'(bus.overrun),   32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      resetn       = 1'b1;
      bus.rx_ready = 1'b1;
      repeat (4) tick();

      // Single byte, consumer always ready.
      v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      exp_q.push_back(8'h34);
      send_byte(8'h34, 0);
      check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      check("t1_frame_err",    32'(ferr_cnt - f0),     32'd0);
      check("t1_overrun",      32'(ovr_cnt - o0),      32'd0);
      check("t1_sb_empty",     32'(exp_q.size()),      32'd0);

      // Three bytes with the consumer stalled.
      bus.rx_ready = 1'b0;
      o0 = ovr_cnt;
      exp_q.push_back(8'h34);
`ifdef UART_RX_FIFO_EN
      exp_q.push_back(8'h32);
      exp_q.push_back(8'h0A);
`endif
      send_byte(8'h34, 0);
      send_byte(8'h32, 0);
      send_byte(8'h0A, 0);
      check("t2_stall_valid", 32'(bus.rx_valid), 32'd1);
      check("t2_stall_data",  32'(bus.rx_data),  32'h34);
`ifdef UART_RX_FIFO_EN
      check("t2_overrun", 32'(ovr_cnt - o0), 32'd0);
`else
      check("t2_overrun", 32'(ovr_cnt - o0), 32'd2);
`endif
      bus.rx_ready = 1'b1;
      repeat (8) tick();
      check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
      check("t2_drained",  32'(bus.rx_valid), 32'd0);

      // Short low glitch rejected at the start-bit sample.
      v0 = valid_cycles; f0 = ferr_cnt;
      bus.rx = 1'b0;
      repeat (3) tick();
      bus.rx = 1'b1;
      repeat (2) tick();
      check("t3_busy_during", 32'(bus.busy), 32'd1);
      repeat (3 * BIT_CLKS) tick();
      check("t3_busy_after",  32'(bus.busy),          32'd0);
      check("t3_no_valid",    32'(valid_cycles - v0), 32'd0);
      check("t3_no_ferr",     32'(ferr_cnt - f0),     32'd0);

      // Stop bit held low for two bit periods, then a clean byte.
      v0 = valid_cycles; f0 = ferr_cnt;
      send_byte(8'h31, 2);
      check("t4_frame_err", 32'(ferr_cnt - f0),     32'd1);
      check("t4_no_valid",  32'(valid_cycles - v0), 32'd0);
      check("t4_idle",      32'(bus.busy),          32'd0);
      v0 = valid_cycles;
      exp_q.push_back(8'h36);
      send_byte(8'h36, 0);
      check("t4_recover_valid", 32'(valid_cycles - v0), 32'd1);
      check("t4_sb_empty",      32'(exp_q.size()),      32'd0);

`ifdef UART_RX_FIFO_EN
      // Fill past capacity with the consumer stalled.
      bus.rx_ready = 1'b0;
      o0 = ovr_cnt;
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      check("t5_overrun", 32'(ovr_cnt - o0), 32'd1);
      bus.rx_ready = 1'b1;
      repeat (10) tick();
      check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Reset mid-frame during bit 4 of 8'hA5; the sender abandons the frame too.
      f0 = ferr_cnt;
      begin
         logic [7:0] a5;
         a5 = 8'hA5;
         bus.rx = 1'b0;
         repeat (BIT_CLKS) tick();
         for (int i = 0; i < 4; i++) begin
            bus.rx = a5[i];
            repeat (BIT_CLKS) tick();
         end
         bus.rx = a5[4];
         repeat (BIT_CLKS / 2) tick();
      end
      check("t6_busy_pre_reset", 32'(bus.busy), 32'd1);
      resetn = 1'b0;
      bus.rx = 1'b1;
      tick();
      resetn = 1'b1;
      check("t6_busy_reset",  32'(bus.busy),     32'd0);
      check("t6_valid_reset", 32'(bus.rx_valid), 32'd0);
      repeat (2 * BIT_CLKS) tick();
      v0 = valid_cycles;
      exp_q.push_back(8'h16);
      send_byte(8'h16, 0);
      check("t6_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      check("t6_sb_empty",     32'(exp_q.size()),      32'd0);
      check("t6_no_ferr",      32'(ferr_cnt - f0),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
